neuron_backprop_update: RTL and testbench

Backward-pass partner to the four-input forward neuron. It holds the neuron's four weights and bias, accepts an error term (delta) for a completed forward evaluation, and sequentially applies the gradient-descent update `w_i ← w_i − (delta·in_i) >>> LR_SHIFT` and `bias ← bias − delta >>> LR_SHIFT`. The updated weights drive the forward neuron's weight and bias inputs, which closes the training loop.

---
 rtl/neuron_backprop_update.sv | 158 +++++++++++++++
 tb/tb_neuron_backprop_update.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_backprop_update.sv
// Gradient-descent updater for a four-input neuron: holds w1..w4 and bias and
// applies one delta-scaled update per register, one register per cycle.
module neuron_backprop_update #(
    parameter int WW       = 16,
    parameter int LR_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           in1,
    input  logic [1:0]           in2,
    input  logic [1:0]           in3,
    input  logic [1:0]           in4,
    input  logic signed [WW-1:0] delta,
    input  logic                 load_en,
    input  logic [2:0]           load_idx,
    input  logic signed [WW-1:0] load_data,
    output logic signed [WW-1:0] w1_out,
    output logic signed [WW-1:0] w2_out,
    output logic signed [WW-1:0] w3_out,
    output logic signed [WW-1:0] w4_out,
    output logic signed [WW-1:0] bias_out,
    output logic                 busy,
    output logic                 done
);

    // state | meaning
    // IDLE  | waiting; load or start accepted (load has priority)
    // UPD0  | update w1 from captured delta and in1
    // UPD1  | update w2
    // UPD2  | update w3
    // UPD3  | update w4
    // BIAS  | update bias with delta alone
    // DONE  | raise done on the way back to IDLE
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UPD0 = 3'd1,
        UPD1 = 3'd2,
        UPD2 = 3'd3,
        UPD3 = 3'd4,
        BIAS = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam int GW = WW + 3;
    localparam int DW = WW + 4;
    localparam logic signed [WW-1:0] W_MAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic signed [WW-1:0] W_MIN = {1'b1, {(WW-1){1'b0}}};

    state_t               state;
    logic signed [WW-1:0] w1, w2, w3, w4, bias;
    logic signed [WW-1:0] delta_c;
    logic [1:0]           in1_c, in2_c, in3_c, in4_c;

    logic [1:0]           in_sel;
    logic signed [WW-1:0] cur;
    logic signed [GW-1:0] delta_x;
    logic signed [GW-1:0] in_x;
    logic signed [GW-1:0] grad;
    logic signed [GW-1:0] step;
    logic signed [DW-1:0] diff;
    logic signed [WW-1:0] sat;
    logic                 load_ok;

    always_comb begin
        in_sel = 2'd0;
        cur    = bias;
        case (state)
            UPD0: begin in_sel = in1_c; cur = w1; end
            UPD1: begin in_sel = in2_c; cur = w2; end
            UPD2: begin in_sel = in3_c; cur = w3; end
            UPD3: begin in_sel = in4_c; cur = w4; end
            default: begin in_sel = 2'd0; cur = bias; end
        endcase
    end

    // The bias step is delta alone; the weight step is delta times the input.
    always_comb begin
        delta_x = {{3{delta_c[WW-1]}}, delta_c};
        in_x    = {{(GW-2){1'b0}}, in_sel};
        grad    = delta_x * in_x;
        step    = (state == BIAS) ? (delta_x >>> LR_SHIFT) : (grad >>> LR_SHIFT);
        diff    = {{(DW-WW){cur[WW-1]}}, cur} - {{(DW-GW){step[GW-1]}}, step};
    end

    // In range exactly when all bits above the result sign agree with it.
    always_comb begin
        if (diff[DW-1:WW-1] == {(DW-WW+1){1'b0}} || diff[DW-1:WW-1] == {(DW-WW+1){1'b1}})
            sat = diff[WW-1:0];
        else if (diff[DW-1])
            sat = W_MIN;
        else
            sat = W_MAX;
    end

    assign load_ok = load_en && !busy;

    // busy is held through the first IDLE cycle after DONE so that it drops
    // only after done has been seen; start is still accepted in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            w1      <= '0;
            w2      <= '0;
            w3      <= '0;
            w4      <= '0;
            bias    <= '0;
            delta_c <= '0;
            in1_c   <= '0;
            in2_c   <= '0;
            in3_c   <= '0;
            in4_c   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        busy <= 1'b0;
                        case (load_idx)
                            3'd0:    w1   <= load_data;
                            3'd1:    w2   <= load_data;
                            3'd2:    w3   <= load_data;
                            3'd3:    w4   <= load_data;
                            3'd4:    bias <= load_data;
                            default: ;
                        endcase
                    end else if (start) begin
                        delta_c <= delta;
                        in1_c   <= in1;
                        in2_c   <= in2;
                        in3_c   <= in3;
                        in4_c   <= in4;
                        busy    <= 1'b1;
                        state   <= UPD0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                UPD0: begin w1 <= sat; state <= UPD1; end
                UPD1: begin w2 <= sat; state <= UPD2; end
                UPD2: begin w3 <= sat; state <= UPD3; end
                UPD3: begin w4 <= sat; state <= BIAS; end
                BIAS: begin bias <= sat; state <= DONE; end
                DONE: begin done <= 1'b1; state <= IDLE; end
                default: state <= IDLE;
            endcase
        end
    end

    assign w1_out   = w1;
    assign w2_out   = w2;
    assign w3_out   = w3;
    assign w4_out   = w4;
    assign bias_out = bias;

endmodule

// File: tb/tb_neuron_backprop_update.sv
// Directed bench for neuron_backprop_update: hand-computed weight updates,
// saturation, protocol conflicts, back-to-back passes and mid-pass reset.
module tb_neuron_backprop_update;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  in1 = '0, in2 = '0, in3 = '0, in4 = '0;
    logic [15:0] delta = '0;
    logic        load_en = 1'b0;
    logic [2:0]  load_idx = '0;
    logic [15:0] load_data = '0;
    logic [15:0] w1_out, w2_out, w3_out, w4_out, bias_out;
    logic        busy, done;

    int tests = 0;
    int fails = 0;

    neuron_backprop_update #(.WW(16), .LR_SHIFT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4), .delta(delta),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
        .w1_out(w1_out), .w2_out(w2_out), .w3_out(w3_out), .w4_out(w4_out),
        .bias_out(bias_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [2:0] idx, input logic [15:0] data);
        load_en = 1'b1; load_idx = idx; load_data = data;
        step_clk();
        load_en = 1'b0;
    endtask

    // Starts a pass, waits (bounded) for done, then steps into the idle cycle.
    task automatic run_pass(input logic [15:0] d, input logic [1:0] a, b, c, e);
        int seen;
        delta = d; in1 = a; in2 = b; in3 = c; in4 = e;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            step_clk();
            if (done === 1'b1) seen = 1;
        end
        tests++;
        if (seen != 1) begin
            fails++;
            $display("FAIL run_pass_done: done seen=%0d required=1", seen);
        end
        step_clk();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({w1_out, w2_out, w3_out, w4_out, bias_out, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_hold: outputs=%h required=0",
                     {w1_out, w2_out, w3_out, w4_out, bias_out, busy, done});
        end
        rst_n = 1'b1;
        repeat (4) step_clk();
        tests++;
        if ({w1_out, w2_out, w3_out, w4_out, bias_out, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_idle: outputs=%h required=0",
                     {w1_out, w2_out, w3_out, w4_out, bias_out, busy, done});
        end
    endtask

    task automatic test_nominal;
        do_load(3'd0, 16'h0100);
        do_load(3'd1, 16'h1234);
        do_load(3'd2, 16'hFFFB);
        do_load(3'd3, 16'h0042);
        do_load(3'd4, 16'h0000);
        delta = 16'h0100; in1 = 2'd3; in2 = 2'd0; in3 = 2'd0; in4 = 2'd0;
        start = 1'b1;
        step_clk();                                  // edge 0
        start = 1'b0; delta = 16'h7777; in1 = 2'd0;  // captured values must be used
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL nom_busy_rise: busy=%b done=%b required busy=1 done=0", busy, done);
        end
        step_clk();                                  // edge 1
        tests++;
        if (w1_out !== 16'h00D0) begin
            fails++;
            $display("FAIL nom_w1: got=%h required=00D0", w1_out);
        end
        repeat (3) step_clk();                       // edge 4
        tests++;
        if (w2_out !== 16'h1234 || w3_out !== 16'hFFFB || w4_out !== 16'h0042 || bias_out !== 16'h0000) begin
            fails++;
            $display("FAIL nom_unchanged: w2=%h w3=%h w4=%h bias=%h required 1234 FFFB 0042 0000",
                     w2_out, w3_out, w4_out, bias_out);
        end
        step_clk();                                  // edge 5
        tests++;
        if (bias_out !== 16'hFFF0 || done !== 1'b0) begin
            fails++;
            $display("FAIL nom_bias: bias=%h done=%b required FFF0 0", bias_out, done);
        end
        step_clk();                                  // edge 6
        tests++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL nom_done: done=%b busy=%b required 1 1", done, busy);
        end
        step_clk();                                  // edge 7
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL nom_end: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_saturation;
        do_load(3'd0, 16'h8010);
        run_pass(16'h7FFF, 2'd3, 2'd0, 2'd0, 2'd0);
        tests++;
        if (w1_out !== 16'h8000) begin
            fails++;
            $display("FAIL neg_sat: w1=%h required=8000", w1_out);
        end
        do_load(3'd1, 16'h7FF0);
        run_pass(16'h8000, 2'd0, 2'd3, 2'd0, 2'd0);
        tests++;
        if (w2_out !== 16'h7FFF || w1_out !== 16'h8000) begin
            fails++;
            $display("FAIL pos_sat: w2=%h w1=%h required 7FFF 8000", w2_out, w1_out);
        end
    endtask

    // Negative steps smaller than one LSB must round toward minus infinity.
    task automatic test_floor;
        do_load(3'd2, 16'h0005);
        do_load(3'd3, 16'h0000);
        do_load(3'd4, 16'h0000);
        run_pass(16'hFFFF, 2'd0, 2'd0, 2'd1, 2'd3);
        tests++;
        if (w3_out !== 16'h0006 || w4_out !== 16'h0001 || bias_out !== 16'h0001 || w1_out !== 16'h8000) begin
            fails++;
            $display("FAIL floor: w3=%h w4=%h bias=%h w1=%h required 0006 0001 0001 8000",
                     w3_out, w4_out, bias_out, w1_out);
        end
    endtask

    task automatic test_conflict;
        int dones;
        do_load(3'd0, 16'h0100);
        do_load(3'd4, 16'h0000);
        delta = 16'h0010; in1 = 2'd1; in2 = 2'd0; in3 = 2'd0; in4 = 2'd0;
        start = 1'b1;
        step_clk();                                  // edge 0
        dones = 0;
        for (int e = 1; e <= 6; e++) begin
            step_clk();
            if (done === 1'b1) dones++;
            if (e == 2) begin load_en = 1'b1; load_idx = 3'd0; load_data = 16'h5555; end
            if (e == 3) load_en = 1'b0;
        end
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_clk();
            if (done === 1'b1) dones++;
        end
        tests++;
        if (dones != 1) begin
            fails++;
            $display("FAIL conflict_one_pass: done pulses=%0d required=1", dones);
        end
        tests++;
        if (w1_out !== 16'h00FF || bias_out !== 16'hFFFF || busy !== 1'b0) begin
            fails++;
            $display("FAIL conflict_load_ignored: w1=%h bias=%h busy=%b required 00FF FFFF 0",
                     w1_out, bias_out, busy);
        end
        load_en = 1'b1; load_idx = 3'd3; load_data = 16'h0777; start = 1'b1;
        step_clk();
        load_en = 1'b0; start = 1'b0;
        tests++;
        if (w4_out !== 16'h0777 || busy !== 1'b0) begin
            fails++;
            $display("FAIL load_wins: w4=%h busy=%b required 0777 0", w4_out, busy);
        end
        repeat (3) step_clk();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || w1_out !== 16'h00FF) begin
            fails++;
            $display("FAIL load_wins_idle: busy=%b done=%b w1=%h required 0 0 00FF", busy, done, w1_out);
        end
    endtask

    task automatic test_back_to_back;
        do_load(3'd0, 16'h0000);
        delta = 16'h0100; in1 = 2'd1; in2 = 2'd0; in3 = 2'd0; in4 = 2'd0;
        start = 1'b1;
        step_clk();                                  // edge 0
        start = 1'b0;
        repeat (6) step_clk();                       // edge 6
        tests++;
        if (done !== 1'b1 || w1_out !== 16'hFFF0) begin
            fails++;
            $display("FAIL b2b_first: done=%b w1=%h required 1 FFF0", done, w1_out);
        end
        start = 1'b1;
        step_clk();                                  // edge 7
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b done=%b required 1 0", busy, done);
        end
        step_clk();                                  // edge 8
        tests++;
        if (w1_out !== 16'hFFE0) begin
            fails++;
            $display("FAIL b2b_second: w1=%h required FFE0", w1_out);
        end
        repeat (8) step_clk();
    endtask

    task automatic test_reset_mid;
        int dones;
        do_load(3'd0, 16'h0100);
        delta = 16'h0100; in1 = 2'd3; in2 = 2'd0; in3 = 2'd0; in4 = 2'd0;
        start = 1'b1;
        step_clk();                                  // edge 0
        start = 1'b0;
        repeat (2) step_clk();                       // in UPD2
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if ({w1_out, w2_out, w3_out, w4_out, bias_out, busy, done} !== '0) begin
            fails++;
            $display("FAIL mid_reset_clear: outputs=%h required=0",
                     {w1_out, w2_out, w3_out, w4_out, bias_out, busy, done});
        end
        step_clk();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            step_clk();
            if (done === 1'b1) dones++;
        end
        tests++;
        if (dones != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_no_done: done pulses=%0d busy=%b required 0 0", dones, busy);
        end
        run_pass(16'h0100, 2'd3, 2'd0, 2'd0, 2'd0);
        tests++;
        if (w1_out !== 16'hFFD0 || bias_out !== 16'hFFF0 || w2_out !== 16'h0000) begin
            fails++;
            $display("FAIL mid_reset_fresh: w1=%h bias=%h w2=%h required FFD0 FFF0 0000",
                     w1_out, bias_out, w2_out);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_floor();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
